// File: rtl/conv_relu_frame_64x64.sv
// conv_relu_frame_64x64: registered ReLU stage that tags each pixel with its raster/channel position.
module conv_relu_frame_64x64 #(
    parameter int DATA_WIDTH      = 32,
    parameter int IMAGE_WIDTH     = 64,
    parameter int IMAGE_HEIGHT    = 64,
    parameter int CHANNEL_NUM_OUT = 304,
    parameter int CH_WIDTH        = 9,
    parameter bit RELU_EN         = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  last_col,
    output logic                  last_row,
    output logic                  last_chan,
    output logic [CH_WIDTH-1:0]   chan_idx,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt
);
    localparam int CW = IMAGE_WIDTH > 1 ? $clog2(IMAGE_WIDTH) : 1;
    localparam int RW = IMAGE_HEIGHT > 1 ? $clog2(IMAGE_HEIGHT) : 1;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [CH_WIDTH-1:0]   chan_q, chan_d, chan_idx_q, chan_idx_d;
    logic [DATA_WIDTH-1:0] pxl_out_q, pxl_out_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  valid_out_q, valid_out_d, last_col_q, last_col_d, last_row_q, last_row_d;
    logic                  last_chan_q, last_chan_d, frame_done_q, frame_done_d;
    logic                  lc, lr, lch, fd;
    always_comb begin
        lc           = col_q == CW'(IMAGE_WIDTH - 1);
        lr           = row_q == RW'(IMAGE_HEIGHT - 1);
        lch          = lc & lr;
        fd           = lch & (chan_q == CH_WIDTH'(CHANNEL_NUM_OUT - 1));
        valid_out_d  = valid_in;
        last_col_d   = valid_in & lc;
        last_row_d   = valid_in & lr;
        last_chan_d  = valid_in & lch;
        frame_done_d = valid_in & fd;
        col_d        = valid_in ? (lc ? '0 : col_q + CW'(1)) : col_q;
        row_d        = valid_in & lc ? (lr ? '0 : row_q + RW'(1)) : row_q;
        chan_d       = valid_in & lch ? (fd ? '0 : chan_q + CH_WIDTH'(1)) : chan_q;
        chan_idx_d   = valid_in ? chan_q : chan_idx_q;
        frame_cnt_d  = valid_in & fd & (frame_cnt_q != 16'hFFFF) ? frame_cnt_q + 16'd1 : frame_cnt_q;
        // Any set sign bit (negatives, -0.0, -inf, negative NaN) clamps to +0.0
        pxl_out_d    = !valid_in ? pxl_out_q : (RELU_EN && pxl_in[DATA_WIDTH-1]) ? '0 : pxl_in;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            chan_q       <= '0;
            chan_idx_q   <= '0;
            pxl_out_q    <= '0;
            frame_cnt_q  <= '0;
            valid_out_q  <= 1'b0;
            last_col_q   <= 1'b0;
            last_row_q   <= 1'b0;
            last_chan_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            chan_q       <= chan_d;
            chan_idx_q   <= chan_idx_d;
            pxl_out_q    <= pxl_out_d;
            frame_cnt_q  <= frame_cnt_d;
            valid_out_q  <= valid_out_d;
            last_col_q   <= last_col_d;
            last_row_q   <= last_row_d;
            last_chan_q  <= last_chan_d;
            frame_done_q <= frame_done_d;
        end
    end
    assign pxl_out    = pxl_out_q;
    assign valid_out  = valid_out_q;
    assign last_col   = last_col_q;
    assign last_row   = last_row_q;
    assign last_chan  = last_chan_q;
    assign chan_idx   = chan_idx_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_conv_relu_frame_64x64.sv
// tb_conv_relu_frame_64x64: small-frame (4x2x3) bench against a position-arithmetic reference model.
module tb_conv_relu_frame_64x64;
    localparam int W = 4, H = 2, C = 3, CHW = 2, FR = W * H * C;
    logic        clk = 1'b0, reset = 1'b1, valid_in = 1'b0;
    logic [31:0] pxl_in = '0;
    logic [31:0] pxl_out, pxl_out0;
    logic        valid_out, last_col, last_row, last_chan, frame_done;
    logic        valid_out0, last_col0, last_row0, last_chan0, frame_done0;
    logic [CHW-1:0] chan_idx, chan_idx0;
    logic [15:0] frame_cnt, frame_cnt0;
    int checks = 0, passed = 0, n = 0;
    logic [31:0] e_pxl, e_pxl0;
    logic        e_valid, e_lc, e_lr, e_lch, e_fd;
    logic [CHW-1:0] e_ci;
    logic [15:0] e_fc;

    conv_relu_frame_64x64 #(.DATA_WIDTH(32), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .CHANNEL_NUM_OUT(C),
        .CH_WIDTH(CHW), .RELU_EN(1'b1)) u_relu (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in), .pxl_out(pxl_out),
        .valid_out(valid_out), .last_col(last_col), .last_row(last_row), .last_chan(last_chan),
        .chan_idx(chan_idx), .frame_done(frame_done), .frame_cnt(frame_cnt));

    conv_relu_frame_64x64 #(.DATA_WIDTH(32), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .CHANNEL_NUM_OUT(C),
        .CH_WIDTH(CHW), .RELU_EN(1'b0)) u_pass (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in), .pxl_out(pxl_out0),
        .valid_out(valid_out0), .last_col(last_col0), .last_row(last_row0), .last_chan(last_chan0),
        .chan_idx(chan_idx0), .frame_done(frame_done0), .frame_cnt(frame_cnt0));

    always #5 clk = ~clk;

    // Drive one cycle, then advance the reference model to what the outputs must show after the edge.
    task automatic drive(input logic v, input logic [31:0] d, input logic r);
        int p;
        @(negedge clk);
        valid_in = v;
        pxl_in   = d;
        reset    = r;
        @(posedge clk);
        #1;
        if (r) begin
            n = 0; e_pxl = '0; e_pxl0 = '0; e_valid = 0; e_lc = 0; e_lr = 0; e_lch = 0; e_fd = 0;
            e_ci = '0; e_fc = '0;
        end else if (v) begin
            p       = n % FR;
            e_valid = 1;
            e_lc    = (p % W) == W - 1;
            e_lr    = ((p / W) % H) == H - 1;
            e_lch   = e_lc && e_lr;
            e_ci    = CHW'(p / (W * H));
            e_fd    = p == FR - 1;
            if (e_fd && e_fc != 16'hFFFF) e_fc = e_fc + 16'd1;
            e_pxl   = d[31] ? 32'd0 : d;
            e_pxl0  = d;
            n++;
        end else begin
            e_valid = 0; e_lc = 0; e_lr = 0; e_lch = 0; e_fd = 0;
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 32'h3F800000, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        checks++;
        if ({pxl_out, valid_out, last_col, last_row, last_chan, frame_done, chan_idx, frame_cnt} !== '0)
            $display("FAIL reset_outputs got pxl=%h v=%b lc=%b lr=%b lch=%b fd=%b ci=%0d fc=%0d want all 0",
                pxl_out, valid_out, last_col, last_row, last_chan, frame_done, chan_idx, frame_cnt);
        else passed++;
    endtask

    task automatic test_sign();
        logic [31:0] vin [5] = '{32'h3F800000, 32'hBF800000, 32'h80000000, 32'h7FC00000, 32'hFFC00000};
        logic [31:0] vout[5] = '{32'h3F800000, 32'h0, 32'h0, 32'h7FC00000, 32'h0};
        logic [31:0] d;
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, vin[i], 1'b0);
            checks++;
            if (pxl_out !== vout[i]) $display("FAIL sign_relu[%0d] got %h want %h", i, pxl_out, vout[i]);
            else passed++;
            checks++;
            if (pxl_out0 !== vin[i]) $display("FAIL sign_pass[%0d] got %h want %h", i, pxl_out0, vin[i]);
            else passed++;
        end
        for (int i = 0; i < 20; i++) begin
            d = $urandom();
            drive(1'b1, d, 1'b0);
            checks++;
            if (pxl_out !== e_pxl || pxl_out0 !== e_pxl0)
                $display("FAIL sign_rand[%0d] got %h/%h want %h/%h", i, pxl_out, pxl_out0, e_pxl, e_pxl0);
            else passed++;
        end
    endtask

    task automatic test_small_frame();
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < FR; i++) begin
            drive(1'b1, $urandom(), 1'b0);
            checks++;
            if ({valid_out, last_col, last_row, last_chan, frame_done, chan_idx} !== {e_valid, e_lc, e_lr, e_lch, e_fd, e_ci}
                || pxl_out !== e_pxl || frame_cnt !== e_fc)
                $display("FAIL frame_px[%0d] got v%b c%b r%b ch%b fd%b ci%0d px%h fc%0d want v%b c%b r%b ch%b fd%b ci%0d px%h fc%0d",
                    i, valid_out, last_col, last_row, last_chan, frame_done, chan_idx, pxl_out, frame_cnt,
                    e_valid, e_lc, e_lr, e_lch, e_fd, e_ci, e_pxl, e_fc);
            else passed++;
        end
        checks++;
        if (frame_done !== 1'b1 || frame_cnt !== 16'd1)
            $display("FAIL frame_end got fd=%b fc=%0d want fd=1 fc=1", frame_done, frame_cnt);
        else passed++;
    endtask

    task automatic test_gaps();
        int g;
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < FR; i++) begin
            g = $urandom_range(0, 5);
            for (int k = 0; k < g; k++) begin
                drive(1'b0, $urandom(), 1'b0);
                checks++;
                if ({valid_out, last_col, last_row, last_chan, frame_done} !== 5'b0 || pxl_out !== e_pxl || chan_idx !== e_ci)
                    $display("FAIL gap_idle[%0d] got v%b c%b r%b ch%b fd%b px%h ci%0d want 0 0 0 0 0 px%h ci%0d",
                        i, valid_out, last_col, last_row, last_chan, frame_done, pxl_out, chan_idx, e_pxl, e_ci);
                else passed++;
            end
            drive(1'b1, $urandom(), 1'b0);
            checks++;
            if ({valid_out, last_col, last_row, last_chan, frame_done, chan_idx} !== {e_valid, e_lc, e_lr, e_lch, e_fd, e_ci}
                || pxl_out !== e_pxl || frame_cnt !== e_fc)
                $display("FAIL gap_px[%0d] got v%b c%b r%b ch%b fd%b ci%0d fc%0d want v%b c%b r%b ch%b fd%b ci%0d fc%0d",
                    i, valid_out, last_col, last_row, last_chan, frame_done, chan_idx, frame_cnt,
                    e_valid, e_lc, e_lr, e_lch, e_fd, e_ci, e_fc);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 2 * FR; i++) begin
            drive(1'b1, $urandom(), 1'b0);
            checks++;
            if ({valid_out, last_col, last_row, last_chan, frame_done, chan_idx} !== {e_valid, e_lc, e_lr, e_lch, e_fd, e_ci}
                || frame_cnt !== e_fc)
                $display("FAIL b2b_px[%0d] got c%b r%b ch%b fd%b ci%0d fc%0d want c%b r%b ch%b fd%b ci%0d fc%0d",
                    i, last_col, last_row, last_chan, frame_done, chan_idx, frame_cnt,
                    e_lc, e_lr, e_lch, e_fd, e_ci, e_fc);
            else passed++;
            if (i == FR) begin
                checks++;
                if (chan_idx !== '0 || last_col !== 1'b0 || frame_done !== 1'b0)
                    $display("FAIL b2b_restart got ci=%0d lc=%b fd=%b want 0 0 0", chan_idx, last_col, frame_done);
                else passed++;
            end
        end
        checks++;
        if (frame_cnt !== 16'd2) $display("FAIL b2b_count got %0d want 2", frame_cnt);
        else passed++;
    endtask

    task automatic test_mid_reset();
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b1, $urandom(), 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h3F800000, 1'b1);
            checks++;
            if ({pxl_out, valid_out, last_col, last_row, last_chan, frame_done, chan_idx, frame_cnt} !== '0)
                $display("FAIL mid_reset_zero[%0d] got px=%h v=%b ci=%0d fc=%0d want 0", i, pxl_out, valid_out, chan_idx, frame_cnt);
            else passed++;
        end
        for (int i = 0; i < FR; i++) begin
            drive(1'b1, $urandom(), 1'b0);
            checks++;
            if ({valid_out, last_col, last_row, last_chan, frame_done, chan_idx} !== {e_valid, e_lc, e_lr, e_lch, e_fd, e_ci}
                || frame_cnt !== e_fc || pxl_out !== e_pxl)
                $display("FAIL post_reset_px[%0d] got c%b r%b ch%b fd%b ci%0d fc%0d want c%b r%b ch%b fd%b ci%0d fc%0d",
                    i, last_col, last_row, last_chan, frame_done, chan_idx, frame_cnt,
                    e_lc, e_lr, e_lch, e_fd, e_ci, e_fc);
            else passed++;
            if (i == 0) begin
                checks++;
                if (chan_idx !== '0 || last_col !== 1'b0 || last_row !== 1'b0)
                    $display("FAIL post_reset_first got ci=%0d lc=%b lr=%b want 0 0 0", chan_idx, last_col, last_row);
                else passed++;
            end
        end
        checks++;
        if (frame_done !== 1'b1 || frame_cnt !== 16'd1)
            $display("FAIL post_reset_done got fd=%b fc=%0d want fd=1 fc=1", frame_done, frame_cnt);
        else passed++;
        drive(1'b1, 32'h3F800000, 1'b1);
        drive(1'b0, 32'h0, 1'b0);
        checks++;
        if (valid_out !== 1'b0) $display("FAIL reset_priority_valid got %b want 0", valid_out);
        else passed++;
        drive(1'b1, 32'h3F800000, 1'b0);
        checks++;
        if (last_col !== 1'b0 || chan_idx !== '0 || valid_out !== 1'b1)
            $display("FAIL reset_priority_pos got v=%b lc=%b ci=%0d want v=1 lc=0 ci=0", valid_out, last_col, chan_idx);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_sign();
        test_small_frame();
        test_gaps();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/conv_relu_frame_64x64.md
# conv_relu_frame_64x64

Output-side post-processing stage placed directly after the 3x3 convolution stage (after its channel-in adder and FIFO alignment). It applies ReLU to the serial 32-bit IEEE-754 single-precision pixel stream. It tracks the raster and output-channel position of every pixel and tags each output with column/row/channel boundary flags plus a channel index, so the next layer's loop-data-in block can frame its input without its own counters. The stage is a single registered pipeline stage with no backpressure.

## Interface
Parameters:
- DATA_WIDTH, 32, pixel word width (IEEE-754 single; sign is bit DATA_WIDTH-1)
- IMAGE_WIDTH, 64, pixels per row
- IMAGE_HEIGHT, 64, rows per channel plane
- CHANNEL_NUM_OUT, 304, channel planes per frame
- CH_WIDTH, 9, width of channel index (must satisfy 2^CH_WIDTH >= CHANNEL_NUM_OUT)
- RELU_EN, 1, 1 = apply ReLU, 0 = pass data unmodified (counters and flags still active)

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- valid_in  input  1  pxl_in is valid this cycle
- pxl_in  input  DATA_WIDTH  input pixel, channel-major order, raster within channel
- pxl_out  output  DATA_WIDTH  processed pixel
- valid_out  output  1  pxl_out and the tag outputs are valid
- last_col  output  1  pxl_out is the last pixel of a row
- last_row  output  1  pxl_out is in the last row of a plane
- last_chan  output  1  pxl_out is the last pixel of a channel plane (last_col & last_row)
- chan_idx  output  CH_WIDTH  output-channel index of pxl_out, 0..CHANNEL_NUM_OUT-1
- frame_done  output  1  one-cycle pulse with the final pixel of channel CHANNEL_NUM_OUT-1
- frame_cnt  output  16  completed frames since reset, saturating at 16'hFFFF

## Operation
- Internal counters: col (0..IMAGE_WIDTH-1), row (0..IMAGE_HEIGHT-1), chan (0..CHANNEL_NUM_OUT-1). They describe the position of the pixel currently at the input.
- Counters advance only on cycles with valid_in=1. Cycles with valid_in=0 leave every counter unchanged, so arbitrary gaps between pixels are allowed.
- Counter advance on each accepted pixel:
  - col increments.
  - At col=IMAGE_WIDTH-1: col goes to 0 and row increments.
  - At row=IMAGE_HEIGHT-1 with col at its last value: row goes to 0 and chan increments.
  - At the last pixel of chan=CHANNEL_NUM_OUT-1: all three counters wrap to 0, frame_done pulses, and frame_cnt increments unless it is already 16'hFFFF.
- ReLU, when RELU_EN=1 and pxl_in[DATA_WIDTH-1]=1: pxl_out=0. This covers negative numbers, -0.0, -inf and negative-sign NaN.
  - Otherwise pxl_in passes bit-exact, including +inf and positive NaN.
- Tags are computed combinationally from the current counters and registered together with the data:
  - last_col = (col==IMAGE_WIDTH-1)
  - last_row = (row==IMAGE_HEIGHT-1)
  - last_chan = last_col & last_row
  - frame_done = last_chan & (chan==CHANNEL_NUM_OUT-1)
  - chan_idx = chan
- No state machine beyond the counters; the frame has no header and sync is purely by count from reset.

## Timing
- Latency 1 cycle: a pixel accepted at edge N appears on pxl_out/valid_out after edge N, with its tags in the same cycle.
- Throughput: one pixel per cycle, sustained; no stall input or output.
- Cycle after valid_in=0: valid_out=0 and last_col, last_row, last_chan and frame_done all 0. pxl_out and chan_idx hold their last values.
- Reset values: pxl_out=0, valid_out=0, last_col=0, last_row=0, last_chan=0, chan_idx=0, frame_done=0, frame_cnt=0. Internal col, row and chan are also 0.
- Reset has priority over valid_in in the same cycle: that pixel is dropped.
- Reset mid-frame discards the position. The next accepted pixel is treated as col 0, row 0, chan 0.
- Back-to-back frames: the pixel following the frame_done pixel is chan 0, col 0, row 0 with no idle cycle required.
- frame_cnt updates in the same cycle that frame_done is high.

## Test plan
- Sign handling, RELU_EN=1, continuous valid. Inputs 0x3F800000, 0xBF800000, 0x80000000, 0x7FC00000, 0xFFC00000 -> outputs 0x3F800000, 0, 0, 0x7FC00000, 0 at 1-cycle latency. With RELU_EN=0 all five pass unchanged.
- Small frame (W=4, H=2, C=3), 24 contiguous pixels:
  - last_col high on output indices 3, 7, 11, 15, 19, 23.
  - last_chan high on 7, 15, 23.
  - chan_idx steps 0→1 at index 8 and 1→2 at index 16.
  - frame_done only on index 23; frame_cnt becomes 1.
- Same frame with random valid_in gaps (up to 5 idle cycles) -> identical tag sequence on valid_out cycles; tags and valid_out all 0 on idle cycles.
- Two back-to-back frames with no gap -> frame_done on pixels 23 and 47; pixel 24 has chan_idx=0; frame_cnt=2.
- Reset asserted after 10 pixels of a frame, then 24 fresh pixels:
  - Outputs are zero during reset.
  - The first post-reset pixel is tagged chan 0, col 0.
  - frame_done falls on the 24th post-reset pixel; frame_cnt=1.
- valid_in=1 in the same cycle as reset -> no valid_out next cycle, and that pixel is not counted.
